// File: rtl/conv3_pkg.sv
// conv3_pkg: shared constants and state encoding for the conv3 job sequencer
package conv3_pkg;
   localparam int NUM_KERNELS  = 10;
   localparam int NUM_CHANNELS = 2;
   localparam int NUM_JOBS     = NUM_KERNELS * NUM_CHANNELS;
   localparam int KIDX_W       = $clog2(NUM_KERNELS);
   localparam int CIDX_W       = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
   localparam int CNT_W        = $clog2(NUM_JOBS + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} conv3_state_t;
endpackage

// File: rtl/conv3_accumulator.sv
// conv3_accumulator: per-kernel partial-sum bank, first channel loads and later channels add
module conv3_accumulator #(
   parameter int BITWIDTH    = 32,
   parameter int NUM_KERNELS = 10,
   parameter int KW          = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  we,
   input  logic                                  first,
   input  logic [KW-1:0]                         k,
   input  logic [BITWIDTH-1:0]                   data,
   output logic [NUM_KERNELS-1:0][BITWIDTH-1:0]  acc
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) acc <= '0;
      else if (we) acc[k] <= first ? data : acc[k] + data;
endmodule

// File: rtl/conv3_scheduler.sv
// conv3_scheduler: issues kernel/channel jobs to one shared engine and accumulates results
module conv3_scheduler #(
   parameter int BITWIDTH     = 32,
   parameter int NUM_KERNELS  = 10,
   parameter int NUM_CHANNELS = 2,
   localparam int KW = NUM_KERNELS > 1 ? $clog2(NUM_KERNELS) : 1,
   localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  pe_issue,
   input  logic                                  pe_ready,
   output logic [KW-1:0]                         pe_kernel_idx,
   output logic [CW-1:0]                         pe_channel_idx,
   input  logic [BITWIDTH-1:0]                   pe_result,
   input  logic                                  pe_result_valid,
   output logic [NUM_KERNELS-1:0][BITWIDTH-1:0]  fm_out,
   output logic                                  fm_valid
);
   import conv3_pkg::*;
   localparam int NJ = NUM_KERNELS * NUM_CHANNELS;
   localparam int NW = $clog2(NJ + 1);
   localparam logic [NW-1:0] LAST = NW'(NJ - 1);
   localparam logic [NW-1:0] ALL  = NW'(NJ);
   localparam logic [CW-1:0] CL   = CW'(NUM_CHANNELS - 1);
   conv3_state_t state, nxt;
   logic [NW-1:0] iss_cnt, res_cnt;
   logic [KW-1:0] rk;
   logic [CW-1:0] rc;
   logic xfer, iss_last, res_ok, go_done;
   assign xfer     = state == ISSUE && pe_ready;
   assign iss_last = xfer && iss_cnt == LAST;
   assign res_ok   = pe_result_valid && (state == ISSUE || state == DRAIN) && res_cnt != ALL;
   assign go_done  = (res_ok && res_cnt == LAST) || res_cnt == ALL;
   assign busy     = state != IDLE;
   assign done     = state == DONE;
   assign pe_issue = state == ISSUE;
   always_comb begin
      nxt = state;
      nxt = state == IDLE  ? (start ? ISSUE : IDLE) :
            state == ISSUE ? (iss_last ? (go_done ? DONE : DRAIN) : ISSUE) :
            state == DRAIN ? (go_done ? DONE : DRAIN) : IDLE;
   end
   // the last issued index is held once all jobs are out
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state          <= IDLE;
         iss_cnt        <= '0;
         res_cnt        <= '0;
         pe_kernel_idx  <= '0;
         pe_channel_idx <= '0;
         rk             <= '0;
         rc             <= '0;
         fm_valid       <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && start) begin
            iss_cnt        <= '0;
            res_cnt        <= '0;
            pe_kernel_idx  <= '0;
            pe_channel_idx <= '0;
            rk             <= '0;
            rc             <= '0;
            fm_valid       <= 1'b0;
         end
         if (state == DONE) fm_valid <= 1'b1;
         if (xfer) begin
            iss_cnt <= iss_cnt + 1'b1;
            if (!iss_last) begin
               pe_channel_idx <= pe_channel_idx == CL ? '0 : pe_channel_idx + 1'b1;
               pe_kernel_idx  <= pe_kernel_idx + KW'(pe_channel_idx == CL);
            end
         end
         if (res_ok) begin
            res_cnt <= res_cnt + 1'b1;
            rc      <= rc == CL ? '0 : rc + 1'b1;
            rk      <= rk + KW'(rc == CL);
         end
      end
   conv3_accumulator #(.BITWIDTH(BITWIDTH), .NUM_KERNELS(NUM_KERNELS), .KW(KW)) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (res_ok),
      .first (rc == '0),
      .k     (rk),
      .data  (pe_result),
      .acc   (fm_out)
   );
endmodule

// File: tb/tb_conv3_scheduler.sv
// tb_conv3_scheduler: scoreboard bench with a latency-1 engine model and directed passes
module tb_conv3_scheduler;
   typedef logic [9:0][31:0] fmv_t;
   typedef struct {int k; int c;} job_t;
   logic clk = 1'b0, rst_n, start, pe_ready, pe_result_valid;
   logic busy, done, pe_issue, fm_valid;
   logic [3:0] kidx;
   logic [0:0] cidx;
   logic [31:0] pe_result;
   fmv_t fm_out, exp0, exp1, exp2, zero_v, mon_e;
   job_t jq[$];
   fmv_t fq[$];
   int lq[$];
   int checks = 0, failures = 0, cyc = 0, t_start = 0, done_cnt = 0, n_xfer = 0, n_pass = 0, mon_l;
   int pass_mode[8];
   bit bp = 0, inj = 0;

   conv3_scheduler dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .pe_issue(pe_issue), .pe_ready(pe_ready), .pe_kernel_idx(kidx), .pe_channel_idx(cidx),
      .pe_result(pe_result), .pe_result_valid(pe_result_valid), .fm_out(fm_out), .fm_valid(fm_valid)
   );

   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", n, a, e, cyc);
      end
   endtask

   task automatic bad(input string n);
      checks++;
      failures++;
      $display("FAIL %s cycle=%0d", n, cyc);
   endtask

   task automatic chk_fm(input string n, input fmv_t e);
      for (int k = 0; k < 10; k++) chk($sformatf("%s[%0d]", n, k), fm_out[k], e[k]);
   endtask

   function automatic logic [31:0] val(input int m, input int k, input int c);
      if (m == 2) return 32'(10 * k + 5 * c);
      if (m == 1 && k == 3) return c == 0 ? 32'hFFFF_FFFF : 32'd2;
      return 32'(100 * k + c + 1);
   endfunction

   // engine model: result for a job one cycle after its transfer
   initial begin
      logic x;
      int kk, cc;
      pe_ready = 1'b0;
      pe_result_valid = 1'b0;
      pe_result = '0;
      forever begin
         @(negedge clk);
         x = pe_issue & pe_ready & rst_n;
         kk = int'(kidx);
         cc = int'(cidx);
         @(posedge clk);
         #1;
         pe_result_valid = x | inj;
         pe_result = inj ? 32'hDEAD_BEEF : val(pass_mode[done_cnt], kk, cc);
         pe_ready = bp ? (cyc % 3 == 0) : 1'b1;
      end
   end

   // monitor: job order / stall hold, and final vector plus latency on done
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (pe_issue) begin
            if (jq.size() == 0) bad("job_unexpected");
            else begin
               chk("job_k", 32'(kidx), 32'(jq[0].k));
               chk("job_c", 32'(cidx), 32'(jq[0].c));
               if (pe_ready) begin
                  void'(jq.pop_front());
                  n_xfer++;
               end
            end
         end
         if (done) begin
            if (fq.size() == 0) bad("done_unexpected");
            else begin
               mon_e = fq.pop_front();
               mon_l = lq.pop_front();
               chk_fm("done_fm", mon_e);
               if (mon_l >= 0) chk("done_latency", cyc - t_start, mon_l);
            end
            done_cnt++;
         end
      end
   end

   task automatic push_exp(input int m, input fmv_t e, input int lat);
      pass_mode[n_pass] = m;
      for (int k = 0; k < 10; k++)
         for (int c = 0; c < 2; c++) jq.push_back('{k, c});
      fq.push_back(e);
      lq.push_back(lat);
      n_pass++;
   endtask

   task automatic pulse();
      @(posedge clk);
      #1 start = 1'b1;
      t_start = cyc;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 400 && done_cnt < target; i++) @(negedge clk);
      if (done_cnt < target) bad("done_timeout");
   endtask

   task automatic after_done();
      @(posedge clk);
      #1;
      chk("post_fm_valid", 32'(fm_valid), 1);
      chk("post_busy", 32'(busy), 0);
      chk("post_done", 32'(done), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      zero_v = '0;
      for (int k = 0; k < 10; k++) begin
         exp0[k] = 32'(200 * k + 3);
         exp2[k] = 32'(20 * k + 5);
      end
      exp1 = exp0;
      exp1[3] = 32'h0000_0001;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_issue", 32'(pe_issue), 0);
      chk("rst_kidx", 32'(kidx), 0);
      chk("rst_cidx", 32'(cidx), 0);
      chk("rst_fm_valid", 32'(fm_valid), 0);
      chk_fm("rst_fm", zero_v);
      @(negedge clk) rst_n = 1'b1;
      // aborted pass: reset after 7 transfers
      pass_mode[0] = 0;
      for (int i = 0; i < 7; i++) jq.push_back('{i / 2, i % 2});
      pulse();
      for (int i = 0; i < 100 && n_xfer < 7; i++) @(negedge clk);
      if (n_xfer < 7) bad("abort_xfer_timeout");
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_issue", 32'(pe_issue), 0);
      chk("abort_kidx", 32'(kidx), 0);
      chk("abort_cidx", 32'(cidx), 0);
      chk("abort_fm_valid", 32'(fm_valid), 0);
      chk_fm("abort_fm", zero_v);
      chk("abort_queue", jq.size(), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 chk("abort_idle", 32'(busy), 0);
      // basic pass
      push_exp(0, exp0, 22);
      pulse();
      wait_done(n_pass);
      after_done();
      // backpressure pass
      @(negedge clk) bp = 1;
      push_exp(0, exp0, -1);
      pulse();
      wait_done(n_pass);
      after_done();
      @(negedge clk) bp = 0;
      // wrap pass
      push_exp(1, exp1, 22);
      pulse();
      wait_done(n_pass);
      after_done();
      // spurious results in IDLE
      @(negedge clk) inj = 1;
      repeat (2) @(negedge clk);
      inj = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_fm("spur_idle_fm", exp1);
      chk("spur_idle_fm_valid", 32'(fm_valid), 1);
      chk("spur_idle_busy", 32'(busy), 0);
      // start pulses while busy
      push_exp(0, exp0, 22);
      pulse();
      for (int i = 2; i <= 23; i++) begin
         @(posedge clk);
         #1 start = (i == 5 || i == 10 || i == 21 || i == 22);
      end
      repeat (40) @(posedge clk);
      #1;
      chk("spur_done_count", done_cnt, n_pass);
      chk("spur_busy", 32'(busy), 0);
      chk_fm("spur_fm", exp0);
      // back-to-back with start held
      push_exp(0, exp0, 22);
      push_exp(2, exp2, 45);
      @(posedge clk);
      #1 start = 1'b1;
      t_start = cyc;
      wait_done(n_pass - 1);
      @(posedge clk);
      #1 chk("b2b_fm_valid_up", 32'(fm_valid), 1);
      @(posedge clk);
      #1;
      chk("b2b_fm_valid_down", 32'(fm_valid), 0);
      chk("b2b_busy", 32'(busy), 1);
      start = 1'b0;
      wait_done(n_pass);
      @(posedge clk);
      #1;
      chk("b2b_fm_valid_final", 32'(fm_valid), 1);
      chk_fm("b2b_fm", exp2);
      repeat (5) @(posedge clk);
      #1;
      chk("final_done_count", done_cnt, 6);
      chk("final_job_queue", jq.size(), 0);
      chk("final_fm_queue", fq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/conv3_scheduler.md
# conv3_scheduler

Sequencer that time-multiplexes one shared 5x5 single-channel dot-product engine (`convolution_point`) across the final convolution stage: 10 kernels × 2 input channels over the 2×5×5 feature map. It issues the 20 kernel/channel jobs in a fixed order, accumulates the two channel partials per kernel, and presents the 10-entry `featuremap3` vector with a start/done handshake. It replaces ten parallel kernel instances with one engine plus an operand mux driven by its index outputs.

## Interface
- `BITWIDTH`, 32, data word width of partials and outputs
- `NUM_KERNELS`, 10, number of output kernels
- `NUM_CHANNELS`, 2, input channels per kernel
---
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a layer pass; sampled only in IDLE
- `busy`  out  1  high from the cycle after start acceptance until the done cycle, inclusive
- `done`  out  1  one-cycle pulse, final accumulation complete
- `pe_issue`  out  1  job valid to engine
- `pe_ready`  in  1  engine accepts job; transfer = `pe_issue & pe_ready`
- `pe_kernel_idx`  out  $clog2(NUM_KERNELS)  kernel selector for operand mux
- `pe_channel_idx`  out  $clog2(NUM_CHANNELS) (min 1)  channel selector for operand mux
- `pe_result`  in  BITWIDTH  engine dot-product result
- `pe_result_valid`  in  1  result strobe; results return in issue order
- `fm_out`  out  [BITWIDTH-1:0] [NUM_KERNELS-1:0]  accumulated output vector
- `fm_valid`  out  1  `fm_out` holds a complete pass

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `start`=1 → ISSUE; clears `fm_valid`, issue counter, result counter.
- ISSUE: `pe_issue`=1; order kernel-major, channel-minor: (k0,c0),(k0,c1),(k1,c0)…(k9,c1). Index advances only on transfer. After transfer of job 20 → DRAIN (or directly DONE if the 20th result arrives in the same cycle).
- DRAIN: `pe_issue`=0; wait until result counter reaches 20 → DONE.
- DONE: `done`=1, `fm_valid`←1 → IDLE.
- Result handling (any state in which results are outstanding): result counter decodes (k,c). c=0: `acc[k] ← pe_result`; c≠0: `acc[k] ← acc[k] + pe_result`, modulo 2^BITWIDTH, no saturation, carry discarded.
- `fm_out` drives `acc` directly; values from the previous pass remain visible until overwritten.
- `pe_kernel_idx`/`pe_channel_idx` hold the current job index while `pe_issue`=1 and stalled; they hold the last value when not issuing.
- `start` while busy: ignored. `pe_result_valid` in IDLE or DONE, or beyond 20 results: ignored, no state change.
- Issue and result in the same cycle: both counters advance independently.
- Reset (any time, incl. mid-pass): state IDLE, counters 0, `acc`=0, all outputs 0.

## Timing
- Reset values: `busy`=0, `done`=0, `pe_issue`=0, indices 0, `fm_out`=all 0, `fm_valid`=0.
- `start` at cycle T (IDLE) → `busy`=1 and first `pe_issue` at T+1.
- With `pe_ready` tied high: jobs transfer T+1..T+20.
- Engine latency L (result for job n at transfer-cycle+L): last result at T+20+L, `done` at T+21+L, IDLE at T+22+L; `start` accepted again at T+22+L.
- `fm_valid` rises in the cycle after `done`, falls the cycle after start acceptance.
- No combinational path from `pe_result_valid` to `pe_issue`; `pe_issue` depends on state only.

## Structure
- Package `conv3_pkg`: `NUM_KERNELS`, `NUM_CHANNELS`, `NUM_JOBS` (=20), index widths, state enum `conv3_state_t`.
- Sub-module `conv3_accumulator`: `acc` register bank with write/add select, kernel index, async reset; FSM and counters stay in `conv3_scheduler`.

## Test plan
- Reset mid-pass: assert `rst_n`=0 after 7 transfers → all outputs 0, IDLE next; fresh `start` completes normally.
- Basic pass, `pe_ready`=1, L=1, model result = 100·k + c + 1 → `fm_out[k]` = 200·k + 3, `done` at T+22, `fm_valid`=1 after.
- Backpressure: `pe_ready` toggles 1,0,0,1… → indices hold during stalls, exactly 20 transfers in order (k0,c0)…(k9,c1), sums identical to basic pass.
- Wrap: k3 partials 0xFFFF_FFFF and 0x0000_0002 → `fm_out[3]`=0x0000_0001.
- Spurious input: `start` pulses while busy and `pe_result_valid` in IDLE → no extra pass, `fm_out` unchanged, single `done`.
- Back-to-back passes: `start` held high → second pass starts at T+22+L, `fm_valid` drops then reasserts with new values.
